feedback_bit_decimator: RTL

//  Consumes the single-bit feedback bitstream produced by the dual-edge

---
 rtl/feedback_bit_decimator.sv | 106 ++++++++++
 1 files changed

// File: rtl/feedback_bit_decimator.sv
// Counts ones in the feedback bitstream over back-to-back windows of WINDOW
// cycles and offers each window's saturated count on a single-slot valid/ready output.
module feedback_bit_decimator #(
  parameter int WINDOW = 200,
  parameter int CNT_W  = 8,
  parameter int PH_W   = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             busy
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_cnt_valid;
  logic             r_overrun;
  logic             r_busy;

  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_result;
  logic             w_last;
  logic             w_complete;
  logic             w_slot_free;

  // One extra carry bit detects overflow so the count clamps instead of wrapping.
  assign w_sum       = {1'b0, r_acc} + (CNT_W+1)'(bit_in);
  assign w_result    = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign w_last      = (r_phase == PH_W'(WINDOW - 1));
  // Dropping en outranks a window finishing in the same cycle.
  assign w_complete  = (r_state == S_ACCUM) && en && w_last;
  assign w_slot_free = !r_cnt_valid || cnt_ready;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_acc       <= '0;
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_ACCUM;
            r_busy  <= 1'b1;
            r_phase <= '0;
            r_acc   <= '0;
          end
        end
        S_ACCUM: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_phase <= '0;
            r_acc   <= '0;
          end else if (w_last) begin
            r_phase <= '0;
            r_acc   <= '0;
          end else begin
            r_phase <= r_phase + PH_W'(1);
            r_acc   <= w_result;
          end
        end
      endcase

      if (w_complete) begin
        if (w_slot_free) begin
          r_cnt_out   <= w_result;
          r_cnt_valid <= 1'b1;
        end
      end else if (r_cnt_valid && cnt_ready) begin
        r_cnt_valid <= 1'b0;
      end

      if (w_complete && !w_slot_free) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign cnt_out   = r_cnt_out;
  assign cnt_valid = r_cnt_valid;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule
